axi_mem_arbiter: RTL
====================

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width on all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 64, data width on R/W channels (wstrb = DATA_W/8).
REQ-003 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port group m0_ar*  input/output  araddr ADDR_W, arid 4, arlen 8, arsize 3, arburst 2, arvalid 1 in; arready 1 out  fetch-master read address.
REQ-006 SHALL have port group m0_r*  output/input  rdata DATA_W, rid 4, rresp 2, rlast 1, rvalid 1 out; rready 1 in  fetch-master read data.
REQ-007 SHALL have port group m1_ar*, m1_r*  same widths as m0  load/store-master read channels.
REQ-008 SHALL have port group m1_aw*  input/output  awaddr ADDR_W, awid 4, awlen 8, awsize 3, awburst 2, awvalid 1 in; awready 1 out  load/store write address.
REQ-009 SHALL have port group m1_w*  input/output  wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1 in; wready 1 out  write data.
REQ-010 SHALL have port group m1_b*  output/input  bid 4, bresp 2, bvalid 1 out; bready 1 in  write response.
REQ-011 SHALL have port groups s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions, same widths  single shared AXI slave (memory model).

Function
REQ-012 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
REQ-013 R_IDLE: with any m*_arvalid and write FSM in W_IDLE with m1_awvalid low, SHALL register the grant and that master's AR fields and go to R_ADDR next cycle.
REQ-014 R_ADDR: s_arvalid=1 from registered fields; on s_arvalid&s_arready SHALL pulse the granted master's arready in that same cycle and go to R_DATA.
REQ-015 R_DATA: s_r* SHALL be routed combinationally to the granted master only; the other master's rvalid=0; s_rready = granted master's rready.
REQ-016 R_DATA -> R_IDLE SHALL occur on s_rvalid&s_rready&s_rlast; a new grant SHALL be possible in the following cycle.
REQ-017 A non-granted master's arready SHALL stay 0; its arvalid SHALL be held, never dropped.
REQ-018 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-019 W_IDLE -> W_ADDR when m1_awvalid and read FSM in R_IDLE; when both want to start in the same cycle the write SHALL win.
REQ-020 W_ADDR: s_aw* = registered m1 AW fields, s_awvalid=1; on handshake m1_awready pulses and FSM goes to W_DATA.
REQ-021 W_DATA: m1_w* passed through to s_w*; on s_wvalid&s_wready&s_wlast go to W_RESP.
REQ-022 W_RESP: s_b* passed to m1_b*; on bvalid&bready go to W_IDLE.
REQ-023 Read and write FSMs SHALL never be simultaneously outside idle (slave serialises).
REQ-024 Minimum read latency: arvalid in cycle N -> s_arvalid in N+1.

Reset
REQ-025 With aresetn=0 at a clock edge, both FSMs SHALL go idle, grant to m0, round-robin pointer to m0; all valid/ready outputs 0 from the next cycle.
REQ-026 Reset mid-burst SHALL abandon the transaction; no further beats are forwarded.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: read grant alternates, last-served master has lowest priority on contention.
REQ-028 Macro undefined: fixed priority, m1 always beats m0 on simultaneous arvalid.

Verification
REQ-029 m0 arvalid, araddr=0x80000000, arlen=3 -> s_arvalid next cycle; 4 beats to m0, m1_rvalid stays 0, R_IDLE after rlast.
REQ-030 m0 and m1 arvalid same cycle with ARB_ROUND_ROBIN_EN, pointer at reset -> m0 served first, then m1; without macro -> m1 first.
REQ-031 m1 awvalid and m0 arvalid same cycle, awaddr=0x80001000, awlen=0, wdata=0x1122334455667788, wstrb=0xFF -> write completes (bvalid, bresp=0) before s_arvalid rises.
REQ-032 Write burst awlen=1 in progress -> m0 arvalid held low-ready, s_arvalid=0 until W_IDLE.
REQ-033 aresetn=0 during third beat of arlen=7 burst -> next cycle all valid/ready outputs 0, both FSMs idle.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Two-master AXI arbiter onto a single memory slave; read and write transactions are serialised.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; otherwise m1 has fixed priority over m0.
module axi_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // fetch master read
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic [3:0]            m0_arid,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [3:0]            m0_rid,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // load/store master read
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic [3:0]            m1_arid,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [3:0]            m1_rid,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // load/store master write
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [3:0]            m1_awid,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [3:0]            m1_bid,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // shared slave
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [3:0]            s_arid,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [3:0]            s_rid,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [3:0]            s_awid,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [3:0]            s_bid,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t          r_rd_state, w_rd_state_nxt;
  wr_state_t          r_wr_state, w_wr_state_nxt;
  logic               r_gnt;        // 1: m1 owns the read path
  logic               w_gnt_sel;
  logic               w_rd_start;
  logic               w_wr_start;

  logic [ADDR_W-1:0]  r_araddr, r_awaddr;
  logic [3:0]         r_arid, r_awid;
  logic [7:0]         r_arlen, r_awlen;
  logic [2:0]         r_arsize, r_awsize;
  logic [1:0]         r_arburst, r_awburst;

`ifdef ARB_ROUND_ROBIN_EN
  logic               r_rr_prio;    // master preferred on the next contention
`endif

  // A pending write address blocks a new read grant, so the write wins a same-cycle tie.
  always_comb begin
    w_wr_start = m1_awvalid && (r_rd_state == R_IDLE) && (r_wr_state == W_IDLE);
    w_rd_start = (m0_arvalid || m1_arvalid) && !m1_awvalid &&
                 (r_rd_state == R_IDLE) && (r_wr_state == W_IDLE);
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_arvalid && m1_arvalid)
      w_gnt_sel = r_rr_prio;
    else
      w_gnt_sel = m1_arvalid;
`else
    w_gnt_sel = m1_arvalid;
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
      r_gnt      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_prio  <= 1'b0;
`endif
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
      if (w_rd_start) begin
        r_gnt <= w_gnt_sel;
`ifdef ARB_ROUND_ROBIN_EN
        r_rr_prio <= !w_gnt_sel;
`endif
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
    end else begin
      if (w_rd_start) begin
        r_araddr  <= w_gnt_sel ? m1_araddr  : m0_araddr;
        r_arid    <= w_gnt_sel ? m1_arid    : m0_arid;
        r_arlen   <= w_gnt_sel ? m1_arlen   : m0_arlen;
        r_arsize  <= w_gnt_sel ? m1_arsize  : m0_arsize;
        r_arburst <= w_gnt_sel ? m1_arburst : m0_arburst;
      end
      if (w_wr_start) begin
        r_awaddr  <= m1_awaddr;
        r_awid    <= m1_awid;
        r_awlen   <= m1_awlen;
        r_awsize  <= m1_awsize;
        r_awburst <= m1_awburst;
      end
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_start) w_rd_state_nxt = R_ADDR;
      R_ADDR:  if (s_arready) w_rd_state_nxt = R_DATA;
      R_DATA:  if (s_rvalid && s_rready && s_rlast) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_start) w_wr_state_nxt = W_ADDR;
      W_ADDR:  if (s_awready) w_wr_state_nxt = W_DATA;
      W_DATA:  if (m1_wvalid && s_wready && m1_wlast) w_wr_state_nxt = W_RESP;
      W_RESP:  if (s_bvalid && m1_bready) w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Read path: address from registered fields, data steered only to the granted master.
  always_comb begin
    s_araddr   = r_araddr;
    s_arid     = r_arid;
    s_arlen    = r_arlen;
    s_arsize   = r_arsize;
    s_arburst  = r_arburst;
    s_arvalid  = (r_rd_state == R_ADDR);
    m0_arready = (r_rd_state == R_ADDR) && !r_gnt && s_arready;
    m1_arready = (r_rd_state == R_ADDR) &&  r_gnt && s_arready;
    m0_rdata   = '0;
    m0_rid     = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rid     = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    s_rready   = 1'b0;
    if (r_rd_state == R_DATA) begin
      if (r_gnt) begin
        m1_rdata  = s_rdata;
        m1_rid    = s_rid;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
        s_rready  = m1_rready;
      end else begin
        m0_rdata  = s_rdata;
        m0_rid    = s_rid;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
        s_rready  = m0_rready;
      end
    end
  end

  always_comb begin
    s_awaddr   = r_awaddr;
    s_awid     = r_awid;
    s_awlen    = r_awlen;
    s_awsize   = r_awsize;
    s_awburst  = r_awburst;
    s_awvalid  = (r_wr_state == W_ADDR);
    m1_awready = (r_wr_state == W_ADDR) && s_awready;
    s_wdata    = m1_wdata;
    s_wstrb    = m1_wstrb;
    s_wlast    = m1_wlast;
    s_wvalid   = (r_wr_state == W_DATA) && m1_wvalid;
    m1_wready  = (r_wr_state == W_DATA) && s_wready;
    m1_bid     = s_bid;
    m1_bresp   = s_bresp;
    m1_bvalid  = (r_wr_state == W_RESP) && s_bvalid;
    s_bready   = (r_wr_state == W_RESP) && m1_bready;
  end

endmodule
